// File: rtl/rca_seq_ctrl_if.sv
// Requester-side bundle for rca_seq_ctrl: the command handshake with its operands, and the
// result handshake with its sum. The block being driven uses the slave modport.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, s, cout, done_valid, busy
    );

    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, s, cout, done_valid, busy
    );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Time-multiplexes one external 4-bit adder slice over a WIDTH-bit add, one nibble per cycle,
// LSB nibble first, with the inter-nibble carry held in a register.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    rca_seq_ctrl_if.slave       bus,
    output logic [3:0]          slice_a,
    output logic [3:0]          slice_b,
    output logic                slice_cin,
    input  logic [3:0]          slice_s,
    input  logic                slice_c4
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDXW-1:0]  idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_q_r;
    logic [WIDTH-1:0] b_q_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             done_valid_r;
    logic             busy_r;
    logic             start_ready_r;

    // Sequencer: accepts a command, walks the nibbles, then holds the result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= '0;
            carry_r       <= 1'b0;
            a_q_r         <= '0;
            b_q_r         <= '0;
            s_r           <= '0;
            cout_r        <= 1'b0;
            done_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_valid && start_ready_r) begin
                        a_q_r         <= bus.a;
                        b_q_r         <= bus.b;
                        carry_r       <= bus.cin;
                        idx_r         <= '0;
                        s_r           <= '0;
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (idx_r == IDXW'(k)) begin
                            s_r[4*k +: 4] <= slice_s;
                        end
                    end
                    carry_r <= slice_c4;
                    // idx wraps to 0 on the last nibble so it never leaves 0..NSLICE-1.
                    if (idx_r == IDX_LAST) begin
                        idx_r        <= '0;
                        cout_r       <= slice_c4;
                        done_valid_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (done_valid_r && bus.done_ready) begin
                        done_valid_r  <= 1'b0;
                        busy_r        <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    idx_r         <= '0;
                    done_valid_r  <= 1'b0;
                    busy_r        <= 1'b0;
                    start_ready_r <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    // Nibble select toward the shared slice; quiet (all zero) outside RUN.
    always_comb begin
        slice_a   = 4'd0;
        slice_b   = 4'd0;
        slice_cin = 1'b0;
        if (state_r == ST_RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (idx_r == IDXW'(k)) begin
                    slice_a = a_q_r[4*k +: 4];
                    slice_b = b_q_r[4*k +: 4];
                end
            end
            slice_cin = carry_r;
        end else begin
            slice_a   = 4'd0;
            slice_b   = 4'd0;
            slice_cin = 1'b0;
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.s           = s_r;
    assign bus.cout        = cout_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.busy        = busy_r;
endmodule
